// File: rtl/csi2_rx_ctrl_pkg.sv
// Shared definitions for the CSI-2 receive link controller: FSM states,
// CSI-2 short-packet data types and the supervision timer width.
package csi2_rx_ctrl_pkg;

   localparam int unsigned TMR_W = 20;

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_PWRUP   = 3'd1,
      ST_WAIT_FS = 3'd2,
      ST_STREAM  = 3'd3,
      ST_RECOVER = 3'd4
   } state_t;

   localparam logic [5:0] DT_FS = 6'h00;
   localparam logic [5:0] DT_FE = 6'h01;
   localparam logic [5:0] DT_LS = 6'h02;
   localparam logic [5:0] DT_LE = 6'h03;

endpackage

// File: rtl/csi2_rx_ctrl_timer.sv
// Down-counter shared by every timed state; o_expire is high while the count sits at zero.
module csi2_rx_ctrl_timer
   import csi2_rx_ctrl_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_reload,
   input  logic [TMR_W-1:0] i_load_val,
   output logic             o_expire
);

   logic [TMR_W-1:0] r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load || i_reload) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/csi2_rx_link_ctrl.sv
// CSI-2 D-PHY link controller: power-up sequencing, frame-sync supervision,
// sticky protocol errors and timeout-driven power-cycle recovery.
module csi2_rx_link_ctrl
   import csi2_rx_ctrl_pkg::*;
#(
   parameter int unsigned      PWRUP_CYCLES   = 8,
   parameter int unsigned      RECOVER_CYCLES = 16,
   parameter logic [TMR_W-1:0] LOCK_TIMEOUT   = 20'hFFFFF,
   parameter logic [TMR_W-1:0] STALL_TIMEOUT  = 20'h3FFFF,
   parameter logic [5:0]       REF_DT         = 6'h2b
) (
   input  logic        clk_byte_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic        clr_err_i,
   input  logic [15:0] expected_wc_i,
   input  logic        sp_en_i,
   input  logic        lp_av_en_i,
   input  logic [5:0]  dt_i,
   input  logic [15:0] wc_i,
   output logic        dphy_pd_o,
   output logic        rx_reset_n_o,
   output logic        link_up_o,
   output logic [2:0]  state_o,
   output logic [15:0] frame_cnt_o,
   output logic [15:0] line_cnt_o,
   output logic [7:0]  retry_cnt_o,
   output logic        err_wc_o,
   output logic        err_dt_o,
   output logic        err_seq_o,
   output logic        err_timeout_o
);

   state_t           r_state, w_next_state;
   logic             r_pd, r_rst_n, r_link_up, r_in_frame;
   logic [15:0]      r_frame_cnt, r_line_cnt, r_run_lines;
   logic [7:0]       r_retry_cnt;
   logic             r_err_wc, r_err_dt, r_err_seq, r_err_to;
   logic             w_pd, w_rst_n, w_link_up;
   logic             w_expire, w_load, w_reload, w_any_pkt;
   logic [TMR_W-1:0] w_load_val;

   assign w_any_pkt = sp_en_i || lp_av_en_i;

   // NOTE: the asynchronous reset is kept to control state and outputs; no memories here need it.
   always_ff @(posedge clk_byte_i or posedge reset_i) begin
      if (reset_i) begin
         r_state   <= ST_OFF;
         r_pd      <= 1'b1;
         r_rst_n   <= 1'b0;
         r_link_up <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_pd      <= w_pd;
         r_rst_n   <= w_rst_n;
         r_link_up <= w_link_up;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_OFF:     w_next_state = ST_PWRUP;
         ST_PWRUP:   if (w_expire) w_next_state = ST_WAIT_FS;
         ST_WAIT_FS: begin
            if (sp_en_i && dt_i == DT_FS) w_next_state = ST_STREAM;
            else if (w_expire)            w_next_state = ST_RECOVER;
         end
         ST_STREAM:  if (w_expire && !w_any_pkt) w_next_state = ST_RECOVER;
         ST_RECOVER: if (w_expire) w_next_state = ST_PWRUP;
         default:    w_next_state = ST_OFF;
      endcase
      if (!enable_i) w_next_state = ST_OFF;
   end

   // Outputs decode the next state so the registered pins move with the state register.
   always_comb begin
      w_pd       = (w_next_state == ST_OFF) || (w_next_state == ST_RECOVER);
      w_rst_n    = (w_next_state == ST_WAIT_FS) || (w_next_state == ST_STREAM);
      w_link_up  = (w_next_state == ST_STREAM);
      w_load_val = '0;
      case (w_next_state)
         ST_PWRUP:   w_load_val = TMR_W'(PWRUP_CYCLES - 1);
         ST_WAIT_FS: w_load_val = LOCK_TIMEOUT - 1'b1;
         ST_STREAM:  w_load_val = STALL_TIMEOUT - 1'b1;
         ST_RECOVER: w_load_val = TMR_W'(RECOVER_CYCLES - 1);
         default:    w_load_val = '0;
      endcase
   end

   assign w_load   = (w_next_state != r_state);
   assign w_reload = (r_state == ST_STREAM) && w_any_pkt;

   csi2_rx_ctrl_timer u_timer (
      .i_clk      (clk_byte_i),
      .i_rst      (reset_i),
      .i_load     (w_load),
      .i_reload   (w_reload),
      .i_load_val (w_load_val),
      .o_expire   (w_expire)
   );

   // Packet decode is qualified by STREAM; a short packet wins over a coincident long one.
   logic w_in_stream, w_fs, w_fe, w_lref, w_lock_fs, w_retry;
   logic w_set_wc, w_set_dt, w_set_seq, w_set_to;

   assign w_in_stream = (r_state == ST_STREAM);
   assign w_fs        = w_in_stream && sp_en_i && dt_i == DT_FS;
   assign w_fe        = w_in_stream && sp_en_i && dt_i == DT_FE;
   assign w_lref      = w_in_stream && lp_av_en_i && !sp_en_i && dt_i == REF_DT;
   assign w_lock_fs   = (r_state == ST_WAIT_FS) && (w_next_state == ST_STREAM);
   assign w_retry     = (r_state == ST_RECOVER) && (w_next_state == ST_PWRUP);
   assign w_set_wc    = w_lref && expected_wc_i != 16'd0 && wc_i != expected_wc_i;
   assign w_set_dt    = w_in_stream && w_any_pkt &&
                        !(dt_i inside {DT_FS, DT_FE, DT_LS, DT_LE, REF_DT});
   assign w_set_seq   = (w_fs && r_in_frame) || (w_fe && !r_in_frame) ||
                        (w_lref && !r_in_frame) || (w_in_stream && sp_en_i && lp_av_en_i);
   assign w_set_to    = (w_next_state == ST_RECOVER) && (r_state != ST_RECOVER);

   always_ff @(posedge clk_byte_i or posedge reset_i) begin
      if (reset_i) begin
         r_in_frame  <= 1'b0;
         r_run_lines <= '0;
         r_frame_cnt <= '0;
         r_line_cnt  <= '0;
         r_retry_cnt <= '0;
         r_err_wc    <= 1'b0;
         r_err_dt    <= 1'b0;
         r_err_seq   <= 1'b0;
         r_err_to    <= 1'b0;
      end else begin
         if (w_lock_fs || w_fs) begin
            r_in_frame  <= 1'b1;
            r_run_lines <= '0;
         end else if (w_fe) begin
            r_in_frame  <= 1'b0;
            r_line_cnt  <= r_run_lines;
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end else if (w_lref && r_run_lines != 16'hFFFF) begin
            r_run_lines <= r_run_lines + 1'b1;
         end
         if (clr_err_i)                       r_retry_cnt <= '0;
         else if (w_retry && r_retry_cnt != 8'hFF) r_retry_cnt <= r_retry_cnt + 1'b1;
         // A new error event in the same cycle as a clear keeps the flag set.
         r_err_wc  <= (r_err_wc  && !clr_err_i) || w_set_wc;
         r_err_dt  <= (r_err_dt  && !clr_err_i) || w_set_dt;
         r_err_seq <= (r_err_seq && !clr_err_i) || w_set_seq;
         r_err_to  <= (r_err_to  && !clr_err_i) || w_set_to;
      end
   end

   assign dphy_pd_o     = r_pd;
   assign rx_reset_n_o  = r_rst_n;
   assign link_up_o     = r_link_up;
   assign state_o       = r_state;
   assign frame_cnt_o   = r_frame_cnt;
   assign line_cnt_o    = r_line_cnt;
   assign retry_cnt_o   = r_retry_cnt;
   assign err_wc_o      = r_err_wc;
   assign err_dt_o      = r_err_dt;
   assign err_seq_o     = r_err_seq;
   assign err_timeout_o = r_err_to;

endmodule

// File: tb/tb_csi2_rx_link_ctrl.sv
// Directed bench for csi2_rx_link_ctrl with shortened lock and stall timeouts.
module tb_csi2_rx_link_ctrl;

   logic        clk_byte_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        enable_i = 1'b0;
   logic        clr_err_i = 1'b0;
   logic [15:0] expected_wc_i = 16'd1280;
   logic        sp_en_i = 1'b0;
   logic        lp_av_en_i = 1'b0;
   logic [5:0]  dt_i = 6'h00;
   logic [15:0] wc_i = 16'd0;
   logic        dphy_pd_o, rx_reset_n_o, link_up_o;
   logic [2:0]  state_o;
   logic [15:0] frame_cnt_o, line_cnt_o;
   logic [7:0]  retry_cnt_o;
   logic        err_wc_o, err_dt_o, err_seq_o, err_timeout_o;

   int checks = 0;
   int errors = 0;

   csi2_rx_link_ctrl #(
      .PWRUP_CYCLES   (8),
      .RECOVER_CYCLES (16),
      .LOCK_TIMEOUT   (20'd100),
      .STALL_TIMEOUT  (20'd50),
      .REF_DT         (6'h2b)
   ) dut (
      .clk_byte_i    (clk_byte_i),
      .reset_i       (reset_i),
      .enable_i      (enable_i),
      .clr_err_i     (clr_err_i),
      .expected_wc_i (expected_wc_i),
      .sp_en_i       (sp_en_i),
      .lp_av_en_i    (lp_av_en_i),
      .dt_i          (dt_i),
      .wc_i          (wc_i),
      .dphy_pd_o     (dphy_pd_o),
      .rx_reset_n_o  (rx_reset_n_o),
      .link_up_o     (link_up_o),
      .state_o       (state_o),
      .frame_cnt_o   (frame_cnt_o),
      .line_cnt_o    (line_cnt_o),
      .retry_cnt_o   (retry_cnt_o),
      .err_wc_o      (err_wc_o),
      .err_dt_o      (err_dt_o),
      .err_seq_o     (err_seq_o),
      .err_timeout_o (err_timeout_o)
   );

   always #5 clk_byte_i = ~clk_byte_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_byte_i);
      #1;
   endtask

   task automatic send_sp(input logic [5:0] dt);
      sp_en_i = 1'b1; dt_i = dt;
      tick();
      sp_en_i = 1'b0;
   endtask

   task automatic send_lp(input logic [5:0] dt, input logic [15:0] wc);
      lp_av_en_i = 1'b1; dt_i = dt; wc_i = wc;
      tick();
      lp_av_en_i = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, state_o, 0);
      check({tag, "_pd"}, dphy_pd_o, 1);
      check({tag, "_rstn"}, rx_reset_n_o, 0);
      check({tag, "_link"}, link_up_o, 0);
      check({tag, "_frames"}, frame_cnt_o, 0);
      check({tag, "_lines"}, line_cnt_o, 0);
      check({tag, "_retry"}, retry_cnt_o, 0);
      check({tag, "_errs"}, {err_wc_o, err_dt_o, err_seq_o, err_timeout_o}, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset and power-up
      tick(); tick();
      check_reset_values("rst");
      reset_i = 1'b0;
      tick();
      check("off_idle_state", state_o, 0);
      enable_i = 1'b1;
      tick();
      check("pwrup_state", state_o, 1);
      check("pwrup_pd", dphy_pd_o, 0);
      check("pwrup_rstn", rx_reset_n_o, 0);
      repeat (7) tick();
      check("pwrup_rstn_held", rx_reset_n_o, 0);
      tick();
      check("pwrup_rstn_rise", rx_reset_n_o, 1);
      check("waitfs_state", state_o, 2);

      // Lock timeout: 100 cycles in WAIT_FS, then 16 cycles of RECOVER
      repeat (99) tick();
      check("lock_wait_state", state_o, 2);
      tick();
      check("lock_to_state", state_o, 4);
      check("lock_to_err", err_timeout_o, 1);
      check("lock_to_pd", dphy_pd_o, 1);
      repeat (15) tick();
      check("recover_pd_held", dphy_pd_o, 1);
      check("recover_state_held", state_o, 4);
      tick();
      check("recover_exit_state", state_o, 1);
      check("recover_exit_pd", dphy_pd_o, 0);
      check("retry_one", retry_cnt_o, 1);
      repeat (8) tick();
      check("relock_waitfs", state_o, 2);
      clr_err_i = 1'b1;
      tick();
      clr_err_i = 1'b0;
      check("clr_timeout", err_timeout_o, 0);
      check("clr_retry", retry_cnt_o, 0);

      // Good frame: FS, four RAW10 lines, FE
      send_sp(6'h00);
      check("fs_link_up", link_up_o, 1);
      check("fs_state", state_o, 3);
      for (int i = 0; i < 4; i++) send_lp(6'h2b, 16'd1280);
      send_sp(6'h01);
      check("good_lines", line_cnt_o, 4);
      check("good_frames", frame_cnt_o, 1);
      check("good_errs", {err_wc_o, err_dt_o, err_seq_o, err_timeout_o}, 0);

      // Protocol errors
      send_sp(6'h00);
      send_lp(6'h2b, 16'd1000);
      check("err_wc", err_wc_o, 1);
      check("err_dt_clean", err_dt_o, 0);
      send_sp(6'h12);
      check("err_dt", err_dt_o, 1);
      check("err_seq_clean", err_seq_o, 0);
      send_sp(6'h01);
      check("fe1_lines", line_cnt_o, 1);
      check("fe1_seq_clean", err_seq_o, 0);
      send_sp(6'h01);
      check("err_seq", err_seq_o, 1);
      check("fe2_frames", frame_cnt_o, 3);
      clr_err_i = 1'b1;
      send_lp(6'h2b, 16'd1000);
      check("clr_vs_wc", err_wc_o, 1);
      check("clr_dt", err_dt_o, 0);
      check("clr_vs_seq", err_seq_o, 1);

      // Stall: last packet above, 50 idle cycles to RECOVER
      tick();
      clr_err_i = 1'b0;
      check("clr_all", {err_wc_o, err_dt_o, err_seq_o}, 0);
      repeat (48) tick();
      check("stall_wait", state_o, 3);
      tick();
      check("stall_recover", state_o, 4);
      check("stall_err", err_timeout_o, 1);
      check("stall_link_down", link_up_o, 0);
      repeat (16) tick();
      check("stall_retry", retry_cnt_o, 1);
      repeat (8) tick();
      check("stall_waitfs", state_o, 2);
      send_sp(6'h00);
      check("restore_link", link_up_o, 1);

      // Disable mid-frame
      send_lp(6'h2b, 16'd1280);
      enable_i = 1'b0;
      tick();
      check("dis_state", state_o, 0);
      check("dis_pd", dphy_pd_o, 1);
      check("dis_link", link_up_o, 0);
      check("dis_frames", frame_cnt_o, 3);
      check("dis_lines", line_cnt_o, 1);
      check("dis_retry", retry_cnt_o, 1);
      check("dis_err_to", err_timeout_o, 1);

      // Asynchronous reset in the middle of RECOVER
      enable_i = 1'b1;
      for (int i = 0; i < 300 && state_o != 3'd4; i++) tick();
      check("reach_recover", state_o, 4);
      repeat (3) tick();
      #2;
      reset_i = 1'b1;
      #1;
      check_reset_values("async_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
